// File: rtl/regfile_bypass_sb_pkg.sv
// rtl/regfile_bypass_sb_pkg.sv - shared defaults and constants for the integer register file
package regfile_bypass_sb_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_AW     = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_BYPASS = 1;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_bypass_sb_if.sv
// rtl/regfile_bypass_sb_if.sv - read, write, issue and conflict signals of the register file
interface regfile_bypass_sb_if #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   wr0_en;
    logic [AW-1:0]          wr0_addr;
    logic [XLEN-1:0]        wr0_data;
    logic                   wr1_en;
    logic [AW-1:0]          wr1_addr;
    logic [XLEN-1:0]        wr1_data;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic                   wr_conflict;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
        input  rd_data, rd_busy, wr_conflict
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
        output rd_data, rd_busy, wr_conflict
    );
endinterface

// File: rtl/regfile_bypass_sb_scoreboard.sv
// rtl/regfile_bypass_sb_scoreboard.sv - one busy bit per register with NUM_RD lookups
// Callers pass enables already qualified against x0 and reset.
module regfile_scoreboard #(
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_set_en,
    input  logic [AW-1:0]        i_set_addr,
    input  logic                 i_clr0_en,
    input  logic [AW-1:0]        i_clr0_addr,
    input  logic                 i_clr1_en,
    input  logic [AW-1:0]        i_clr1_addr,
    input  logic [NUM_RD*AW-1:0] i_rd_addr,
    output logic [NUM_RD-1:0]    o_busy
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_next;

    // Set is applied last so a new producer supersedes a retiring one.
    always_comb begin
        w_busy_next = r_busy;
        if (i_clr0_en) w_busy_next[i_clr0_addr] = 1'b0;
        if (i_clr1_en) w_busy_next[i_clr1_addr] = 1'b0;
        if (i_set_en)  w_busy_next[i_set_addr]  = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_busy <= '0;
        else       r_busy <= w_busy_next;
    end

    always_comb begin
        o_busy = '0;
        for (int k = 0; k < NUM_RD; k++) o_busy[k] = r_busy[i_rd_addr[k*AW +: AW]];
    end
endmodule

// File: rtl/regfile_bypass_sb.sv
// rtl/regfile_bypass_sb.sv - parametrised register file with write bypass and busy scoreboard
// Holds the storage array, write arbitration (load return wins), read muxes and conflict flag.
module regfile_bypass_sb
    import regfile_bypass_sb_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREGS  = DEF_NREGS,
    parameter int AW     = DEF_AW,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int BYPASS = DEF_BYPASS
) (
    input  logic              clk,
    input  logic              reset,
    regfile_bypass_sb_if.slave bus
);
    if (NREGS != (1 << AW)) begin : g_bad_size
        $error("regfile_bypass_sb: NREGS must equal 2**AW");
    end

    logic [XLEN-1:0]   r_regs [NREGS];
    logic              r_conflict;
    logic              w_wr0_ok;
    logic              w_wr1_ok;
    logic              w_iss_ok;
    logic [AW-1:0]     w_ra [NUM_RD];
    logic [NUM_RD-1:0] w_fwd;
    logic [NUM_RD-1:0] w_sb_busy;

    assign w_wr0_ok = bus.wr0_en && (bus.wr0_addr != AW'(REG_ZERO)) && !reset;
    assign w_wr1_ok = bus.wr1_en && (bus.wr1_addr != AW'(REG_ZERO)) && !reset;
    assign w_iss_ok = bus.iss_en && (bus.iss_addr != AW'(REG_ZERO)) && !reset;

    // wr1 is written second so the load return wins an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_conflict <= 1'b0;
        end else begin
            if (w_wr0_ok) r_regs[bus.wr0_addr] <= bus.wr0_data;
            if (w_wr1_ok) r_regs[bus.wr1_addr] <= bus.wr1_data;
            r_conflict <= w_wr0_ok && w_wr1_ok && (bus.wr0_addr == bus.wr1_addr);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) w_ra[k] = bus.rd_addr[k*AW +: AW];
    end

    always_comb begin
        bus.rd_data = '0;
        w_fwd       = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_fwd[k] = (BYPASS != 0) && w_ra[k] != AW'(REG_ZERO) &&
                       ((w_wr1_ok && bus.wr1_addr == w_ra[k]) || (w_wr0_ok && bus.wr0_addr == w_ra[k]));
            if (w_ra[k] == AW'(REG_ZERO))
                bus.rd_data[k*XLEN +: XLEN] = '0;
            else if (BYPASS != 0 && w_wr1_ok && bus.wr1_addr == w_ra[k])
                bus.rd_data[k*XLEN +: XLEN] = bus.wr1_data;
            else if (BYPASS != 0 && w_wr0_ok && bus.wr0_addr == w_ra[k])
                bus.rd_data[k*XLEN +: XLEN] = bus.wr0_data;
            else
                bus.rd_data[k*XLEN +: XLEN] = r_regs[w_ra[k]];
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .AW     (AW),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .i_set_en    (w_iss_ok),
        .i_set_addr  (bus.iss_addr),
        .i_clr0_en   (w_wr0_ok),
        .i_clr0_addr (bus.wr0_addr),
        .i_clr1_en   (w_wr1_ok),
        .i_clr1_addr (bus.wr1_addr),
        .i_rd_addr   (bus.rd_addr),
        .o_busy      (w_sb_busy)
    );

    // A value being forwarded this cycle is already available, so it is not reported busy.
    assign bus.rd_busy     = w_sb_busy & ~w_fwd;
    assign bus.wr_conflict = r_conflict;
endmodule
